pwm_meas: RTL and testbench

Parameterised PWM measurement block, the successor to the 8-bit duty counter. It measures both high time and period of a PWM input, in clk cycles, between consecutive rising edges. It provides a valid strobe, input synchronisation, saturation, and stuck-high/stuck-low detection. It sits between the PWM input pins and the control/telemetry logic that computes duty ratio.

---
 rtl/pwm_meas.sv | 151 +++++++++++++++
 tb/tb_pwm_meas.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_meas.sv
// Measures PWM high time and rise-to-rise period in clk cycles, with stuck-high/low detection.
// Latency: PWM edge to rise detect is SYNC_STAGES+1 clks; capture appears one clk later. No backpressure.
module pwm_meas #(
   parameter int CNT_W       = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             PWM,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period,
   output logic             meas_vld,
   output logic             stuck_hi,
   output logic             stuck_lo
);

   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             w_pwm_s;
   logic             r_pwm_p;
   logic             w_rise;
   logic             w_timeout;

   logic [CNT_W-1:0] r_per_c;
   logic [CNT_W-1:0] r_hi_c;
   logic             r_armed;
   logic [CNT_W-1:0] r_high_cnt;
   logic [CNT_W-1:0] r_period;
   logic             r_meas_vld;
   logic             r_stuck_hi;
   logic             r_stuck_lo;

   logic [CNT_W-1:0] w_per_c_nxt;
   logic [CNT_W-1:0] w_hi_c_nxt;
   logic             w_armed_nxt;
   logic [CNT_W-1:0] w_high_cnt_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic             w_meas_vld_nxt;
   logic             w_stuck_hi_nxt;
   logic             w_stuck_lo_nxt;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_pwm_s = PWM;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= PWM;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_sync[i] <= r_sync[i-1];
               end
            end
         end

         assign w_pwm_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Edge detector keeps running while disabled so a rise right at re-enable is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_p <= 1'b0;
      end else begin
         r_pwm_p <= w_pwm_s;
      end
   end

   assign w_rise    = w_pwm_s & ~r_pwm_p;
   assign w_timeout = (r_per_c == MAX) && !w_rise;

   always_comb begin
      w_per_c_nxt    = r_per_c;
      w_hi_c_nxt     = r_hi_c;
      w_armed_nxt    = r_armed;
      w_high_cnt_nxt = r_high_cnt;
      w_period_nxt   = r_period;
      w_meas_vld_nxt = 1'b0;
      w_stuck_hi_nxt = r_stuck_hi;
      w_stuck_lo_nxt = r_stuck_lo;

      if (!en) begin
         w_per_c_nxt    = '0;
         w_hi_c_nxt     = '0;
         w_armed_nxt    = 1'b0;
         w_stuck_hi_nxt = 1'b0;
         w_stuck_lo_nxt = 1'b0;
      end else if (w_rise) begin
         // Counters still hold the completed period here; reload after sampling.
         if (r_armed) begin
            w_high_cnt_nxt = r_hi_c;
            w_period_nxt   = r_per_c;
            w_meas_vld_nxt = 1'b1;
         end
         w_per_c_nxt    = ONE;
         w_hi_c_nxt     = ONE;
         w_armed_nxt    = 1'b1;
         w_stuck_hi_nxt = 1'b0;
         w_stuck_lo_nxt = 1'b0;
      end else begin
         if (r_per_c != MAX) begin
            w_per_c_nxt = r_per_c + ONE;
         end
         if (w_pwm_s && (r_hi_c != MAX)) begin
            w_hi_c_nxt = r_hi_c + ONE;
         end
         if (w_timeout) begin
            w_armed_nxt = 1'b0;
            // First flag to fire stays put even if the level flips while saturated.
            if (!r_stuck_hi && !r_stuck_lo) begin
               w_stuck_hi_nxt = w_pwm_s;
               w_stuck_lo_nxt = ~w_pwm_s;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_per_c    <= '0;
         r_hi_c     <= '0;
         r_armed    <= 1'b0;
         r_high_cnt <= '0;
         r_period   <= '0;
         r_meas_vld <= 1'b0;
         r_stuck_hi <= 1'b0;
         r_stuck_lo <= 1'b0;
      end else begin
         r_per_c    <= w_per_c_nxt;
         r_hi_c     <= w_hi_c_nxt;
         r_armed    <= w_armed_nxt;
         r_high_cnt <= w_high_cnt_nxt;
         r_period   <= w_period_nxt;
         r_meas_vld <= w_meas_vld_nxt;
         r_stuck_hi <= w_stuck_hi_nxt;
         r_stuck_lo <= w_stuck_lo_nxt;
      end
   end

   assign high_cnt = r_high_cnt;
   assign period   = r_period;
   assign meas_vld = r_meas_vld;
   assign stuck_hi = r_stuck_hi;
   assign stuck_lo = r_stuck_lo;

endmodule

// File: tb/tb_pwm_meas.sv
// Bench for pwm_meas: a 12-bit instance for capture/enable/reset behaviour, a 4-bit one for stuck detection.
module tb_pwm_meas;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a_n, en_a, pwm_a;
   logic [11:0] hc_a, per_a;
   logic        vld_a, shi_a, slo_a;

   logic        rst_b_n, en_b, pwm_b;
   logic [3:0]  hc_b, per_b;
   logic        vld_b, shi_b, slo_b;

   int n_checks = 0;
   int n_errors = 0;
   int q_hi_a[$], q_per_a[$], q_hi_b[$], q_per_b[$];
   logic prev_vld_a = 1'b0;
   logic prev_vld_b = 1'b0;

   pwm_meas #(.CNT_W(12), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .en(en_a), .PWM(pwm_a),
      .high_cnt(hc_a), .period(per_a), .meas_vld(vld_a),
      .stuck_hi(shi_a), .stuck_lo(slo_a)
   );

   pwm_meas #(.CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .en(en_b), .PWM(pwm_b),
      .high_cnt(hc_b), .period(per_b), .meas_vld(vld_b),
      .stuck_hi(shi_b), .stuck_lo(slo_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One PWM period; its measurement is reported by the rise that starts the next one.
   task automatic drive_a(input int h, input int l);
      pwm_a = 1'b1;
      cyc(h);
      pwm_a = 1'b0;
      cyc(l);
      q_hi_a.push_back(h);
      q_per_a.push_back(h + l);
   endtask

   task automatic drive_b(input int h, input int l);
      pwm_b = 1'b1;
      cyc(h);
      pwm_b = 1'b0;
      cyc(l);
      q_hi_b.push_back(h);
      q_per_b.push_back(h + l);
   endtask

   always @(negedge clk) begin
      if (vld_a) begin
         check("vld_a_width", {31'd0, prev_vld_a}, 32'd0);
         if (q_hi_a.size() == 0) check("vld_a_unexpected", {31'd0, vld_a}, 32'd0);
         else begin
            check("cap_a_high", {20'd0, hc_a}, q_hi_a.pop_front());
            check("cap_a_period", {20'd0, per_a}, q_per_a.pop_front());
         end
      end
      prev_vld_a = vld_a;
   end

   always @(negedge clk) begin
      if (vld_b) begin
         check("vld_b_width", {31'd0, prev_vld_b}, 32'd0);
         if (q_hi_b.size() == 0) check("vld_b_unexpected", {31'd0, vld_b}, 32'd0);
         else begin
            check("cap_b_high", {28'd0, hc_b}, q_hi_b.pop_front());
            check("cap_b_period", {28'd0, per_b}, q_per_b.pop_front());
         end
      end
      prev_vld_b = vld_b;
   end

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      en_a = 1'b0;    en_b = 1'b0;
      pwm_a = 1'b0;   pwm_b = 1'b0;
      cyc(3);
      check("rst_high_cnt", {20'd0, hc_a}, 32'd0);
      check("rst_period", {20'd0, per_a}, 32'd0);
      check("rst_meas_vld", {31'd0, vld_a}, 32'd0);
      check("rst_stuck_hi", {31'd0, shi_a}, 32'd0);
      check("rst_stuck_lo", {31'd0, slo_a}, 32'd0);

      // 3/5 stream then duty change to 6/2; the first rise only arms.
      rst_a_n = 1'b1;
      en_a = 1'b1;
      cyc(2);
      repeat (4) drive_a(3, 5);
      repeat (3) drive_a(6, 2);
      pwm_a = 1'b1; cyc(3);
      pwm_a = 1'b0; cyc(2);
      check("stream_q_empty", q_hi_a.size(), 32'd0);
      check("stream_last_high", {20'd0, hc_a}, 32'd6);
      check("stream_last_period", {20'd0, per_a}, 32'd8);

      // Enable dropped mid-period: outputs hold, re-arm needed afterwards.
      en_a = 1'b0;
      repeat (3) begin
         cyc(1);
         check("en0_hold_high", {20'd0, hc_a}, 32'd6);
         check("en0_hold_period", {20'd0, per_a}, 32'd8);
         check("en0_stuck", {30'd0, shi_a, slo_a}, 32'd0);
      end
      en_a = 1'b1;
      cyc(2);
      drive_a(4, 6);
      check("reen_hold_high", {20'd0, hc_a}, 32'd6);
      check("reen_hold_period", {20'd0, per_a}, 32'd8);
      drive_a(4, 6);
      pwm_a = 1'b1; cyc(5);
      check("reen_q_empty", q_hi_a.size(), 32'd0);
      check("reen_high", {20'd0, hc_a}, 32'd4);
      check("reen_period", {20'd0, per_a}, 32'd10);

      // Asynchronous reset while PWM is high.
      #2 rst_a_n = 1'b0;
      #1;
      check("arst_high_cnt", {20'd0, hc_a}, 32'd0);
      check("arst_period", {20'd0, per_a}, 32'd0);
      check("arst_flags", {29'd0, vld_a, shi_a, slo_a}, 32'd0);
      pwm_a = 1'b0;
      cyc(2);
      rst_a_n = 1'b1;
      cyc(2);
      repeat (2) drive_a(3, 5);
      pwm_a = 1'b1; cyc(5);
      pwm_a = 1'b0;
      check("arst_q_empty", q_hi_a.size(), 32'd0);
      check("arst_high", {20'd0, hc_a}, 32'd3);
      check("arst_period", {20'd0, per_a}, 32'd8);

      // CNT_W=4: low from reset gives stuck_lo once per_c sits at 15.
      en_b = 1'b1;
      rst_b_n = 1'b1;
      cyc(14);
      check("slo_early", {31'd0, slo_b}, 32'd0);
      cyc(2);
      check("slo_set", {31'd0, slo_b}, 32'd1);
      check("slo_no_shi", {31'd0, shi_b}, 32'd0);
      cyc(4);
      check("slo_stays", {31'd0, slo_b}, 32'd1);
      drive_b(3, 5);
      check("slo_cleared", {31'd0, slo_b}, 32'd0);

      // High for 20 cycles: capture of 3/8, then stuck_hi with outputs held.
      pwm_b = 1'b1;
      cyc(20);
      check("shi_set", {31'd0, shi_b}, 32'd1);
      check("shi_no_slo", {31'd0, slo_b}, 32'd0);
      check("shi_hold_high", {28'd0, hc_b}, 32'd3);
      check("shi_hold_period", {28'd0, per_b}, 32'd8);
      pwm_b = 1'b0;
      cyc(4);
      check("shi_level_flip", {30'd0, shi_b, slo_b}, 32'd2);
      drive_b(2, 3);
      check("shi_cleared", {30'd0, shi_b, slo_b}, 32'd0);
      pwm_b = 1'b1; cyc(5);
      check("b_q_empty", q_hi_b.size(), 32'd0);
      check("b_high", {28'd0, hc_b}, 32'd2);
      check("b_period", {28'd0, per_b}, 32'd5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
